// File: rtl/text_overlay_pkg.sv
// -----------------------------------------------------------------------------
// text_overlay_pkg
// Shared definitions for the VGA text overlay and its character-buffer writer:
//   - ASCII codes the writer interprets (space, CR, LF, BS, FF, printable range)
//   - default buffer geometry (6 rows x 50 cols of an 8x16 font)
//   - writer FSM state encoding and cursor-counter operation codes
// -----------------------------------------------------------------------------
package text_overlay_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] PRINT_MIN   = 8'h20;
  localparam logic [7:0] PRINT_MAX   = 8'h7E;

  // Buffer geometry shared with the overlay read side.
  localparam int ROWS2       = 6;
  localparam int COLS2       = 50;
  localparam int CHAR_WIDTH  = 8;
  localparam int CHAR_HEIGHT = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } writer_state_e;

  typedef enum logic [2:0] {
    CUR_HOLD    = 3'd0,
    CUR_ADVANCE = 3'd1,  // col+1, wrapping into the next row, row wraps to 0
    CUR_DEC_COL = 3'd2,  // col-1, caller guarantees col > 0
    CUR_HOME    = 3'd3,  // (0,0)
    CUR_NEWLINE = 3'd4,  // row+1 with wrap, col=0
    CUR_CR      = 3'd5   // col=0, row unchanged
  } cursor_op_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// -----------------------------------------------------------------------------
// text_cursor
// Row/column position counter for the character buffer. One operation per
// cycle selected by iOp; the position wraps at COLS-1 / ROWS-1 (no scrolling).
// Ports:
//   iCLK, iRST_N : clock, asynchronous active-low reset (position -> (0,0))
//   iOp          : operation to apply on this clock edge
//   oRow, oCol   : current position (registered)
// -----------------------------------------------------------------------------
module text_cursor
  import text_overlay_pkg::*;
#(
  parameter int ROWS  = ROWS2,
  parameter int COLS  = COLS2,
  parameter int ROW_W = 3,
  parameter int COL_W = 6
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  cursor_op_e       iOp,
  output logic [ROW_W-1:0] oRow,
  output logic [COL_W-1:0] oCol
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [ROW_W-1:0] row_q, row_d, row_inc;
  logic [COL_W-1:0] col_q, col_d;

  assign row_inc = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    case (iOp)
      CUR_ADVANCE: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_inc;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      CUR_DEC_COL: col_d = col_q - COL_W'(1);
      CUR_HOME: begin
        row_d = '0;
        col_d = '0;
      end
      CUR_NEWLINE: begin
        row_d = row_inc;
        col_d = '0;
      end
      CUR_CR:  col_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign oRow = row_q;
  assign oCol = col_q;

endmodule

// File: rtl/text_buffer_writer.sv
// -----------------------------------------------------------------------------
// text_buffer_writer
// Writer side of the on-screen character buffer. Turns an ASCII byte stream
// into single-cycle writes on the character RAM write port, tracks a cursor,
// interprets CR/LF/BS/FF, and sweeps the whole buffer with spaces after reset,
// on iClear, or on FF.
//
// Handshake: a byte is transferred on a rising edge where iValid & oReady.
// oReady is combinational, high only in IDLE with no iClear that cycle, so a
// byte presented together with iClear is never taken. iValid may be held
// across cycles; one byte per cycle is accepted while oReady stays high.
//
// Ports:
//   iCLK, iRST_N       : clock, asynchronous active-low reset
//   iData, iValid      : byte source; oReady : writer accepts this cycle
//   iClear             : single-cycle clear request
//   oWe, oWr_row, oWr_col, oWr_data : registered RAM write port
//   oCursor_row, oCursor_col        : cursor (sweep position while clearing)
//   oBusy              : clear sweep in progress; doubles as FSM state view
// -----------------------------------------------------------------------------
module text_buffer_writer
  import text_overlay_pkg::*;
#(
  parameter int ROWS  = ROWS2,
  parameter int COLS  = COLS2,
  parameter int ROW_W = 3,
  parameter int COL_W = 6
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [7:0]       iData,
  input  logic             iValid,
  output logic             oReady,
  input  logic             iClear,
  output logic             oWe,
  output logic [ROW_W-1:0] oWr_row,
  output logic [COL_W-1:0] oWr_col,
  output logic [7:0]       oWr_data,
  output logic [ROW_W-1:0] oCursor_row,
  output logic [COL_W-1:0] oCursor_col,
  output logic             oBusy
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  writer_state_e    state_q, state_d;
  logic             busy_q, busy_d;
  logic             we_q, we_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [7:0]       wr_data_q, wr_data_d;

  cursor_op_e       cur_op;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             accept;
  logic             last_cell;

  // The same counter serves as the sweep position during CLEAR and as the
  // text cursor in IDLE; both start from (0,0) so no hand-over is needed.
  text_cursor #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_cursor (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iOp    (cur_op),
    .oRow   (cur_row),
    .oCol   (cur_col)
  );

  assign oReady    = (state_q == ST_IDLE) && !iClear;
  assign accept    = iValid && oReady;
  assign last_cell = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  always_comb begin
    state_d   = state_q;
    cur_op    = CUR_HOLD;
    we_d      = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;

    if (iClear) begin
      // Restart from any state; the pending cell (if clearing) is not written.
      state_d = ST_CLEAR;
      cur_op  = CUR_HOME;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          we_d      = 1'b1;
          wr_row_d  = cur_row;
          wr_col_d  = cur_col;
          wr_data_d = ASCII_SPACE;
          if (last_cell) begin
            state_d = ST_IDLE;
            cur_op  = CUR_HOME;
          end else begin
            cur_op  = CUR_ADVANCE;
          end
        end
        default: begin
          if (accept) begin
            if (is_printable(iData)) begin
              we_d      = 1'b1;
              wr_row_d  = cur_row;
              wr_col_d  = cur_col;
              wr_data_d = iData;
              cur_op    = CUR_ADVANCE;
            end else begin
              case (iData)
                ASCII_CR: cur_op = CUR_CR;
                ASCII_LF: cur_op = CUR_NEWLINE;
                ASCII_BS: begin
                  // Backspace never wraps back into the previous row.
                  if (cur_col != '0) begin
                    we_d      = 1'b1;
                    wr_row_d  = cur_row;
                    wr_col_d  = cur_col - COL_W'(1);
                    wr_data_d = ASCII_SPACE;
                    cur_op    = CUR_DEC_COL;
                  end
                end
                ASCII_FF: begin
                  state_d = ST_CLEAR;
                  cur_op  = CUR_HOME;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end

    // Held through the cycle that shows the final sweep write, so oBusy
    // falls one cycle after the last oWe of the sweep.
    busy_d = (state_d == ST_CLEAR) || (state_q == ST_CLEAR);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_CLEAR;
      busy_q    <= 1'b1;
      we_q      <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= ASCII_SPACE;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign oWe         = we_q;
  assign oWr_row     = wr_row_q;
  assign oWr_col     = wr_col_q;
  assign oWr_data    = wr_data_q;
  assign oCursor_row = cur_row;
  assign oCursor_col = cur_col;
  assign oBusy       = busy_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// -----------------------------------------------------------------------------
// tb_text_buffer_writer
// Directed bench for text_buffer_writer at default geometry (6 x 50).
// -----------------------------------------------------------------------------
module tb_text_buffer_writer;

  localparam int ROWS  = 6;
  localparam int COLS  = 50;
  localparam int CELLS = ROWS * COLS;
  localparam int W     = 17;  // {row[2:0], col[5:0], data[7:0]}

  logic       iCLK, iRST_N, iValid, iClear;
  logic [7:0] iData;
  logic       oReady, oWe, oBusy;
  logic [2:0] oWr_row, oCursor_row;
  logic [5:0] oWr_col, oCursor_col;
  logic [7:0] oWr_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] mon_q[$];
  logic [W-1:0] exp_q[$];

  text_buffer_writer dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iData       (iData),
    .iValid      (iValid),
    .oReady      (oReady),
    .iClear      (iClear),
    .oWe         (oWe),
    .oWr_row     (oWr_row),
    .oWr_col     (oWr_col),
    .oWr_data    (oWr_data),
    .oCursor_row (oCursor_row),
    .oCursor_col (oCursor_col),
    .oBusy       (oBusy)
  );

  // ---------------- clock / reset ----------------
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Write monitor: every RAM write, sampled away from the active edge.
  always @(negedge iCLK) begin
    if (oWe === 1'b1) mon_q.push_back({oWr_row, oWr_col, oWr_data});
  end

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the falling edge.
  task automatic tick();
    @(negedge iCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    iValid = 1'b1;
    iData  = b;
    tick();
    iValid = 1'b0;
  endtask

  // Waits for oBusy to fall; reports oWe as seen on the sample before it fell.
  task automatic wait_sweep(output bit done, output logic we_before_drop);
    done = 1'b0;
    we_before_drop = 1'bx;
    for (int k = 0; k < CELLS + 100 && !done; k++) begin
      we_before_drop = oWe;
      tick();
      if (oBusy === 1'b0) done = 1'b1;
    end
  endtask

  task automatic wait_writes(input int n, output bit done);
    done = 1'b0;
    for (int k = 0; k < 2 * n + 20 && !done; k++) begin
      if (mon_q.size() >= n) done = 1'b1;
      else tick();
    end
  endtask

  function automatic logic [W-1:0] sweep_exp(input int i);
    return {3'(i / COLS), 6'(i % COLS), 8'h20};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    bit done;
    logic wb;
    iRST_N = 1'b0;
    tick();
    tick();
    n_checks++; if (oWe !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, expected 0", oWe); end
    n_checks++; if (oWr_row !== 3'd0) begin n_fail++; $display("FAIL reset_wr_row: got %0d, expected 0", oWr_row); end
    n_checks++; if (oWr_col !== 6'd0) begin n_fail++; $display("FAIL reset_wr_col: got %0d, expected 0", oWr_col); end
    n_checks++; if (oWr_data !== 8'h20) begin n_fail++; $display("FAIL reset_wr_data: got %h, expected 20", oWr_data); end
    n_checks++; if ({oCursor_row, oCursor_col} !== 9'd0) begin n_fail++; $display("FAIL reset_cursor: got (%0d,%0d), expected (0,0)", oCursor_row, oCursor_col); end
    n_checks++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b, expected 1", oBusy); end
    n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, expected 0", oReady); end

    mon_q.delete();
    iRST_N = 1'b1;
    wait_sweep(done, wb);
    n_checks++; if (!done) begin n_fail++; $display("FAIL powerup_sweep_timeout: oBusy still %b, expected 0", oBusy); end
    n_checks++; if (wb !== 1'b1) begin n_fail++; $display("FAIL powerup_busy_drop: oWe before drop %b, expected 1", wb); end
    n_checks++; if (mon_q.size() != CELLS) begin n_fail++; $display("FAIL powerup_sweep_count: got %0d, expected %0d", mon_q.size(), CELLS); end
    exp_q.delete();
    for (int i = 0; i < CELLS; i++) exp_q.push_back(sweep_exp(i));
    for (int i = 0; i < mon_q.size() && exp_q.size() > 0; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (mon_q[i] !== e) begin n_fail++; $display("FAIL powerup_sweep_cell%0d: got %h, expected %h", i, mon_q[i], e); end
    end
    n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL powerup_ready: got %b, expected 1", oReady); end
    n_checks++; if ({oCursor_row, oCursor_col} !== 9'd0) begin n_fail++; $display("FAIL powerup_cursor: got (%0d,%0d), expected (0,0)", oCursor_row, oCursor_col); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s [5];
    s = '{8'h41, 8'h52, 8'h4D, 8'h45, 8'h44};  // "ARMED"
    for (int i = 0; i < 5; i++) begin
      iValid = 1'b1;
      iData  = s[i];
      tick();
      n_checks++;
      if ({oWe, oWr_row, oWr_col, oWr_data} !== {1'b1, 3'd0, 6'(i), s[i]}) begin
        n_fail++;
        $display("FAIL armed_write%0d: got we=%b (%0d,%0d)=%h, expected we=1 (0,%0d)=%h", i, oWe, oWr_row, oWr_col, oWr_data, i, s[i]);
      end
    end
    iValid = 1'b0;
    n_checks++; if ({oCursor_row, oCursor_col} !== {3'd0, 6'd5}) begin n_fail++; $display("FAIL armed_cursor: got (%0d,%0d), expected (0,5)", oCursor_row, oCursor_col); end
  endtask

  task automatic test_wrap();
    send_byte(8'h0D);
    n_checks++; if ({oWe, oCursor_row, oCursor_col} !== {1'b0, 3'd0, 6'd0}) begin n_fail++; $display("FAIL wrap_cr: got we=%b cursor (%0d,%0d), expected we=0 (0,0)", oWe, oCursor_row, oCursor_col); end
    for (int i = 0; i < COLS; i++) begin
      iValid = 1'b1;
      iData  = 8'h58;
      tick();
      n_checks++;
      if ({oWe, oWr_row, oWr_col, oWr_data} !== {1'b1, 3'd0, 6'(i), 8'h58}) begin
        n_fail++;
        $display("FAIL wrap_x%0d: got we=%b (%0d,%0d)=%h, expected we=1 (0,%0d)=58", i, oWe, oWr_row, oWr_col, oWr_data, i);
      end
    end
    iData = 8'h59;
    tick();
    iValid = 1'b0;
    n_checks++; if ({oWe, oWr_row, oWr_col, oWr_data} !== {1'b1, 3'd1, 6'd0, 8'h59}) begin n_fail++; $display("FAIL wrap_y: got we=%b (%0d,%0d)=%h, expected we=1 (1,0)=59", oWe, oWr_row, oWr_col, oWr_data); end
    n_checks++; if ({oCursor_row, oCursor_col} !== {3'd1, 6'd1}) begin n_fail++; $display("FAIL wrap_y_cursor: got (%0d,%0d), expected (1,1)", oCursor_row, oCursor_col); end
    for (int i = 0; i < 4; i++) send_byte(8'h0A);
    for (int i = 0; i < COLS - 1; i++) send_byte(8'h58);
    n_checks++; if ({oCursor_row, oCursor_col} !== {3'd5, 6'd49}) begin n_fail++; $display("FAIL wrap_corner_cursor: got (%0d,%0d), expected (5,49)", oCursor_row, oCursor_col); end
    send_byte(8'h5A);
    n_checks++; if ({oWe, oWr_row, oWr_col, oWr_data} !== {1'b1, 3'd5, 6'd49, 8'h5A}) begin n_fail++; $display("FAIL wrap_z: got we=%b (%0d,%0d)=%h, expected we=1 (5,49)=5a", oWe, oWr_row, oWr_col, oWr_data); end
    n_checks++; if ({oCursor_row, oCursor_col} !== 9'd0) begin n_fail++; $display("FAIL wrap_z_cursor: got (%0d,%0d), expected (0,0)", oCursor_row, oCursor_col); end
  endtask

  task automatic test_control_codes();
    send_byte(8'h0A);
    send_byte(8'h0A);
    for (int i = 0; i < 7; i++) send_byte(8'h58);
    n_checks++; if ({oCursor_row, oCursor_col} !== {3'd2, 6'd7}) begin n_fail++; $display("FAIL ctl_setup_cursor: got (%0d,%0d), expected (2,7)", oCursor_row, oCursor_col); end
    send_byte(8'h08);
    n_checks++; if ({oWe, oWr_row, oWr_col, oWr_data} !== {1'b1, 3'd2, 6'd6, 8'h20}) begin n_fail++; $display("FAIL ctl_bs_write: got we=%b (%0d,%0d)=%h, expected we=1 (2,6)=20", oWe, oWr_row, oWr_col, oWr_data); end
    n_checks++; if ({oCursor_row, oCursor_col} !== {3'd2, 6'd6}) begin n_fail++; $display("FAIL ctl_bs_cursor: got (%0d,%0d), expected (2,6)", oCursor_row, oCursor_col); end
    send_byte(8'h0D);
    n_checks++; if ({oWe, oCursor_row, oCursor_col} !== {1'b0, 3'd2, 6'd0}) begin n_fail++; $display("FAIL ctl_cr: got we=%b cursor (%0d,%0d), expected we=0 (2,0)", oWe, oCursor_row, oCursor_col); end
    send_byte(8'h08);
    n_checks++; if ({oWe, oCursor_row, oCursor_col} !== {1'b0, 3'd2, 6'd0}) begin n_fail++; $display("FAIL ctl_bs_col0: got we=%b cursor (%0d,%0d), expected we=0 (2,0)", oWe, oCursor_row, oCursor_col); end
    send_byte(8'h0A);
    n_checks++; if ({oWe, oCursor_row, oCursor_col} !== {1'b0, 3'd3, 6'd0}) begin n_fail++; $display("FAIL ctl_lf: got we=%b cursor (%0d,%0d), expected we=0 (3,0)", oWe, oCursor_row, oCursor_col); end
    send_byte(8'h07);
    n_checks++; if ({oWe, oCursor_row, oCursor_col} !== {1'b0, 3'd3, 6'd0}) begin n_fail++; $display("FAIL ctl_bel: got we=%b cursor (%0d,%0d), expected we=0 (3,0)", oWe, oCursor_row, oCursor_col); end
    send_byte(8'h0A);
    send_byte(8'h0A);
    send_byte(8'h0A);
    n_checks++; if ({oWe, oCursor_row, oCursor_col} !== {1'b0, 3'd0, 6'd0}) begin n_fail++; $display("FAIL ctl_lf_wrap: got we=%b cursor (%0d,%0d), expected we=0 (0,0)", oWe, oCursor_row, oCursor_col); end
  endtask

  task automatic test_clear_pulse();
    bit done;
    logic wb;
    mon_q.delete();
    iValid = 1'b1;
    iData  = 8'h51;
    iClear = 1'b1;
    #1;
    n_checks++; if (oReady !== 1'b0) begin n_fail++; $display("FAIL clr_ready: got %b, expected 0", oReady); end
    tick();
    iValid = 1'b0;
    iClear = 1'b0;
    n_checks++; if ({oWe, oBusy} !== 2'b01) begin n_fail++; $display("FAIL clr_enter: got we=%b busy=%b, expected we=0 busy=1", oWe, oBusy); end
    wait_writes(100, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL clr_first100_timeout: got %0d writes, expected 100", mon_q.size()); end
    for (int i = 0; i < 100 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== sweep_exp(i)) begin n_fail++; $display("FAIL clr_cell%0d: got %h, expected %h", i, mon_q[i], sweep_exp(i)); end
    end
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    mon_q.delete();
    wait_sweep(done, wb);
    n_checks++; if (!done) begin n_fail++; $display("FAIL restart_timeout: oBusy still %b, expected 0", oBusy); end
    n_checks++; if (mon_q.size() != CELLS) begin n_fail++; $display("FAIL restart_count: got %0d, expected %0d", mon_q.size(), CELLS); end
    exp_q.delete();
    for (int i = 0; i < CELLS; i++) exp_q.push_back(sweep_exp(i));
    for (int i = 0; i < mon_q.size() && exp_q.size() > 0; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (mon_q[i] !== e) begin n_fail++; $display("FAIL restart_cell%0d: got %h, expected %h", i, mon_q[i], e); end
    end
    n_checks++; if ({oReady, oCursor_row, oCursor_col} !== {1'b1, 9'd0}) begin n_fail++; $display("FAIL restart_end: got ready=%b cursor (%0d,%0d), expected ready=1 (0,0)", oReady, oCursor_row, oCursor_col); end
  endtask

  task automatic test_ff_and_reset();
    bit done;
    logic wb;
    send_byte(8'h41);
    n_checks++; if ({oWe, oWr_row, oWr_col, oWr_data} !== {1'b1, 3'd0, 6'd0, 8'h41}) begin n_fail++; $display("FAIL ff_a_write: got we=%b (%0d,%0d)=%h, expected we=1 (0,0)=41", oWe, oWr_row, oWr_col, oWr_data); end
    send_byte(8'h07);
    n_checks++; if ({oWe, oCursor_row, oCursor_col} !== {1'b0, 3'd0, 6'd1}) begin n_fail++; $display("FAIL ff_bel: got we=%b cursor (%0d,%0d), expected we=0 (0,1)", oWe, oCursor_row, oCursor_col); end
    send_byte(8'h0C);
    mon_q.delete();
    n_checks++; if ({oWe, oBusy, oReady} !== 3'b010) begin n_fail++; $display("FAIL ff_enter: got we=%b busy=%b ready=%b, expected 0/1/0", oWe, oBusy, oReady); end
    wait_writes(50, done);
    n_checks++; if (!done) begin n_fail++; $display("FAIL ff_sweep_timeout: got %0d writes, expected 50", mon_q.size()); end
    for (int i = 0; i < 50 && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== sweep_exp(i)) begin n_fail++; $display("FAIL ff_cell%0d: got %h, expected %h", i, mon_q[i], sweep_exp(i)); end
    end
    iRST_N = 1'b0;
    #1;
    n_checks++; if ({oWe, oBusy, oWr_row, oWr_col, oWr_data} !== {1'b0, 1'b1, 3'd0, 6'd0, 8'h20}) begin n_fail++; $display("FAIL midreset_outputs: got we=%b busy=%b (%0d,%0d)=%h, expected we=0 busy=1 (0,0)=20", oWe, oBusy, oWr_row, oWr_col, oWr_data); end
    n_checks++; if ({oCursor_row, oCursor_col} !== 9'd0) begin n_fail++; $display("FAIL midreset_cursor: got (%0d,%0d), expected (0,0)", oCursor_row, oCursor_col); end
    tick();
    tick();
    iRST_N = 1'b1;
    mon_q.delete();
    wait_sweep(done, wb);
    n_checks++; if (!done) begin n_fail++; $display("FAIL midreset_sweep_timeout: oBusy still %b, expected 0", oBusy); end
    n_checks++; if (wb !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_drop: oWe before drop %b, expected 1", wb); end
    n_checks++; if (mon_q.size() != CELLS) begin n_fail++; $display("FAIL midreset_count: got %0d, expected %0d", mon_q.size(), CELLS); end
    exp_q.delete();
    for (int i = 0; i < CELLS; i++) exp_q.push_back(sweep_exp(i));
    for (int i = 0; i < mon_q.size() && exp_q.size() > 0; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (mon_q[i] !== e) begin n_fail++; $display("FAIL midreset_cell%0d: got %h, expected %h", i, mon_q[i], e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    iRST_N = 1'b0;
    iValid = 1'b0;
    iClear = 1'b0;
    iData  = 8'h00;
    test_reset();
    test_back_to_back();
    test_wrap();
    test_control_codes();
    test_clear_pulse();
    test_ff_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
